// File: rtl/pu_riscv_bp_resolve_if.sv
// pu_riscv_bp_resolve_if: decode/execute/predictor-update signals of the branch resolution unit
interface pu_riscv_bp_resolve_if #(
  parameter int XLEN           = 64,
  parameter int BP_GLOBAL_BITS = 2,
  parameter int DEPTH          = 4
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic                      id_push_i;
  logic [1:0]                id_predict_i;
  logic                      id_stall_o;
  logic                      ex_resolve_i;
  logic [XLEN-1:0]           ex_pc_i;
  logic                      ex_btaken_i;
  logic                      ex_flush_i;
  logic [BP_GLOBAL_BITS-1:0] spec_history_o;
  logic                      bu_bp_update_o;
  logic [XLEN-1:0]           bu_bp_pc_o;
  logic [BP_GLOBAL_BITS-1:0] bu_bp_history_o;
  logic [1:0]                bu_bp_predict_o;
  logic                      bu_bp_btaken_o;
  logic                      mispredict_o;
  logic [CW-1:0]             count_o;
  logic                      error_o;
  modport master (
    output id_push_i, id_predict_i, ex_resolve_i, ex_pc_i, ex_btaken_i, ex_flush_i,
    input  id_stall_o, spec_history_o, bu_bp_update_o, bu_bp_pc_o, bu_bp_history_o,
           bu_bp_predict_o, bu_bp_btaken_o, mispredict_o, count_o, error_o
  );
  modport slave (
    input  id_push_i, id_predict_i, ex_resolve_i, ex_pc_i, ex_btaken_i, ex_flush_i,
    output id_stall_o, spec_history_o, bu_bp_update_o, bu_bp_pc_o, bu_bp_history_o,
           bu_bp_predict_o, bu_bp_btaken_o, mispredict_o, count_o, error_o
  );
endinterface

// File: rtl/pu_riscv_bp_resolve.sv
// pu_riscv_bp_resolve: tracks predicted branches decode->execute, keeps global histories, emits predictor updates
module pu_riscv_bp_resolve #(
  parameter int XLEN           = 64,
  parameter int BP_GLOBAL_BITS = 2,
  parameter int DEPTH          = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  pu_riscv_bp_resolve_if.slave bp
);
  localparam int G  = BP_GLOBAL_BITS;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = G + 2;
  logic [DEPTH-1:0][EW-1:0] mem_q, mem_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [G-1:0]             spec_q, spec_d, commit_q, commit_d;
  logic                     update_q, update_d, mis_q, mis_d, btaken_q, btaken_d, error_q, error_d;
  logic [XLEN-1:0]          pc_q, pc_d;
  logic [G-1:0]             hist_q, hist_d;
  logic [1:0]               pred_q, pred_d;
  logic [EW-1:0]            head;
  logic                     full, resolve_ok, mis, clear, push_ok;
  always_comb begin
    head       = mem_q[rd_ptr_q];
    full       = count_q == CW'(DEPTH);
    resolve_ok = bp.ex_resolve_i && count_q != '0;
    mis        = resolve_ok && (bp.ex_btaken_i != head[G+1]);
    clear      = mis || bp.ex_flush_i;
    // a correct resolve frees the head slot, so a push is still accepted when full
    push_ok    = bp.id_push_i && !clear && (!full || resolve_ok);
    commit_d   = resolve_ok ? ((commit_q << 1) | G'(bp.ex_btaken_i)) : commit_q;
    spec_d     = clear ? commit_d : push_ok ? ((spec_q << 1) | G'(bp.id_predict_i[1])) : spec_q;
    mem_d      = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = {bp.id_predict_i, spec_q};
    rd_ptr_d   = clear ? '0 : rd_ptr_q + PW'(resolve_ok);
    wr_ptr_d   = clear ? '0 : wr_ptr_q + PW'(push_ok);
    count_d    = clear ? '0 : count_q + CW'(push_ok) - CW'(resolve_ok);
    error_d    = error_q || (bp.ex_resolve_i && count_q == '0)
               || (bp.id_push_i && full && !resolve_ok && !bp.ex_flush_i);
    update_d   = resolve_ok;
    mis_d      = mis;
    pc_d       = resolve_ok ? bp.ex_pc_i : pc_q;
    hist_d     = resolve_ok ? head[G-1:0] : hist_q;
    pred_d     = resolve_ok ? head[G+:2] : pred_q;
    btaken_d   = resolve_ok ? bp.ex_btaken_i : btaken_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      spec_q   <= '0;
      commit_q <= '0;
      update_q <= 1'b0;
      mis_q    <= 1'b0;
      btaken_q <= 1'b0;
      error_q  <= 1'b0;
      pc_q     <= '0;
      hist_q   <= '0;
      pred_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      spec_q   <= spec_d;
      commit_q <= commit_d;
      update_q <= update_d;
      mis_q    <= mis_d;
      btaken_q <= btaken_d;
      error_q  <= error_d;
      pc_q     <= pc_d;
      hist_q   <= hist_d;
      pred_q   <= pred_d;
    end
  end
  assign bp.id_stall_o      = count_q == CW'(DEPTH);
  assign bp.spec_history_o  = spec_q;
  assign bp.bu_bp_update_o  = update_q;
  assign bp.bu_bp_pc_o      = pc_q;
  assign bp.bu_bp_history_o = hist_q;
  assign bp.bu_bp_predict_o = pred_q;
  assign bp.bu_bp_btaken_o  = btaken_q;
  assign bp.mispredict_o    = mis_q;
  assign bp.count_o         = count_q;
  assign bp.error_o         = error_q;
endmodule

// File: tb/tb_pu_riscv_bp_resolve.sv
// tb_pu_riscv_bp_resolve: directed scenario bench for the branch resolution unit
module tb_pu_riscv_bp_resolve;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  pu_riscv_bp_resolve_if #(.XLEN(64), .BP_GLOBAL_BITS(2), .DEPTH(4)) bp ();
  pu_riscv_bp_resolve #(.XLEN(64), .BP_GLOBAL_BITS(2), .DEPTH(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bp(bp.slave)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bp.id_push_i = 0; bp.id_predict_i = 0; bp.ex_resolve_i = 0;
    bp.ex_pc_i = 0; bp.ex_btaken_i = 0; bp.ex_flush_i = 0;
  endtask
  task automatic push(input logic [1:0] p);
    bp.id_push_i = 1; bp.id_predict_i = p;
    step();
    idle();
  endtask
  task automatic resolve(input logic [63:0] pc, input logic t);
    bp.ex_resolve_i = 1; bp.ex_pc_i = pc; bp.ex_btaken_i = t;
    step();
    idle();
  endtask
  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask
  task automatic test_reset();
    idle();
    do_reset();
    checks++;
    if ({bp.bu_bp_update_o, bp.bu_bp_pc_o, bp.bu_bp_history_o, bp.bu_bp_predict_o, bp.bu_bp_btaken_o, bp.mispredict_o} !== 71'd0) begin
      errors++; $display("FAIL reset_update: got upd=%b pc=%h hist=%b pred=%b bt=%b mis=%b expected all 0", bp.bu_bp_update_o, bp.bu_bp_pc_o, bp.bu_bp_history_o, bp.bu_bp_predict_o, bp.bu_bp_btaken_o, bp.mispredict_o);
    end
    checks++;
    if ({bp.count_o, bp.spec_history_o, bp.id_stall_o, bp.error_o} !== 7'd0) begin
      errors++; $display("FAIL reset_state: got count=%0d spec=%b stall=%b err=%b expected all 0", bp.count_o, bp.spec_history_o, bp.id_stall_o, bp.error_o);
    end
  endtask
  task automatic test_back_to_back();
    push(2'b11);
    push(2'b00);
    checks++;
    if (bp.spec_history_o !== 2'b10 || bp.count_o !== 3'd2) begin
      errors++; $display("FAIL b2b_push: got spec=%b count=%0d expected spec=10 count=2", bp.spec_history_o, bp.count_o);
    end
    resolve(64'h100, 1'b1);
    checks++;
    if ({bp.bu_bp_update_o, bp.bu_bp_pc_o, bp.bu_bp_history_o, bp.bu_bp_predict_o, bp.bu_bp_btaken_o, bp.mispredict_o}
        !== {1'b1, 64'h100, 2'b00, 2'b11, 1'b1, 1'b0}) begin
      errors++; $display("FAIL b2b_upd1: got upd=%b pc=%h hist=%b pred=%b bt=%b mis=%b expected 1 100 00 11 1 0", bp.bu_bp_update_o, bp.bu_bp_pc_o, bp.bu_bp_history_o, bp.bu_bp_predict_o, bp.bu_bp_btaken_o, bp.mispredict_o);
    end
    resolve(64'h104, 1'b0);
    checks++;
    if ({bp.bu_bp_update_o, bp.bu_bp_pc_o, bp.bu_bp_history_o, bp.bu_bp_predict_o, bp.bu_bp_btaken_o, bp.mispredict_o}
        !== {1'b1, 64'h104, 2'b01, 2'b00, 1'b0, 1'b0}) begin
      errors++; $display("FAIL b2b_upd2: got upd=%b pc=%h hist=%b pred=%b bt=%b mis=%b expected 1 104 01 00 0 0", bp.bu_bp_update_o, bp.bu_bp_pc_o, bp.bu_bp_history_o, bp.bu_bp_predict_o, bp.bu_bp_btaken_o, bp.mispredict_o);
    end
    checks++;
    if (bp.spec_history_o !== 2'b10 || bp.count_o !== 3'd0) begin
      errors++; $display("FAIL b2b_spec: got spec=%b count=%0d expected spec=10 count=0", bp.spec_history_o, bp.count_o);
    end
    step();
    checks++;
    if (bp.bu_bp_update_o !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got upd=%b expected 0", bp.bu_bp_update_o);
    end
  endtask
  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) push(2'b11);
    checks++;
    if (bp.id_stall_o !== 1'b1 || bp.count_o !== 3'd4 || bp.spec_history_o !== 2'b11) begin
      errors++; $display("FAIL full_stall: got stall=%b count=%0d spec=%b expected 1 4 11", bp.id_stall_o, bp.count_o, bp.spec_history_o);
    end
    bp.id_push_i = 1; bp.id_predict_i = 2'b11;
    bp.ex_resolve_i = 1; bp.ex_pc_i = 64'h200; bp.ex_btaken_i = 1;
    step();
    idle();
    checks++;
    if ({bp.count_o, bp.error_o, bp.bu_bp_update_o, bp.mispredict_o} !== {3'd4, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL full_pushres: got count=%0d err=%b upd=%b mis=%b expected 4 0 1 0", bp.count_o, bp.error_o, bp.bu_bp_update_o, bp.mispredict_o);
    end
    push(2'b01);
    checks++;
    if (bp.error_o !== 1'b1 || bp.count_o !== 3'd4 || bp.spec_history_o !== 2'b11) begin
      errors++; $display("FAIL full_overflow: got err=%b count=%0d spec=%b expected 1 4 11", bp.error_o, bp.count_o, bp.spec_history_o);
    end
  endtask
  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 3; i++) push(2'b10);
    checks++;
    if (bp.spec_history_o !== 2'b11 || bp.count_o !== 3'd3) begin
      errors++; $display("FAIL mis_setup: got spec=%b count=%0d expected 11 3", bp.spec_history_o, bp.count_o);
    end
    resolve(64'h300, 1'b0);
    checks++;
    if ({bp.mispredict_o, bp.bu_bp_update_o, bp.bu_bp_history_o, bp.bu_bp_predict_o, bp.bu_bp_btaken_o, bp.count_o, bp.spec_history_o}
        !== {1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 3'd0, 2'b00}) begin
      errors++; $display("FAIL mis_pulse: got mis=%b upd=%b hist=%b pred=%b bt=%b count=%0d spec=%b expected 1 1 00 10 0 0 00", bp.mispredict_o, bp.bu_bp_update_o, bp.bu_bp_history_o, bp.bu_bp_predict_o, bp.bu_bp_btaken_o, bp.count_o, bp.spec_history_o);
    end
    step();
    checks++;
    if (bp.mispredict_o !== 1'b0 || bp.bu_bp_update_o !== 1'b0 || bp.error_o !== 1'b0) begin
      errors++; $display("FAIL mis_after: got mis=%b upd=%b err=%b expected 0 0 0", bp.mispredict_o, bp.bu_bp_update_o, bp.error_o);
    end
  endtask
  task automatic test_flush();
    for (int i = 0; i < 3; i++) push(2'b11);
    bp.ex_flush_i = 1; bp.ex_resolve_i = 1; bp.ex_pc_i = 64'h400; bp.ex_btaken_i = 1;
    step();
    idle();
    checks++;
    if ({bp.bu_bp_update_o, bp.mispredict_o, bp.bu_bp_pc_o, bp.bu_bp_history_o, bp.count_o, bp.spec_history_o}
        !== {1'b1, 1'b0, 64'h400, 2'b00, 3'd0, 2'b01}) begin
      errors++; $display("FAIL flush_res: got upd=%b mis=%b pc=%h hist=%b count=%0d spec=%b expected 1 0 400 00 0 01", bp.bu_bp_update_o, bp.mispredict_o, bp.bu_bp_pc_o, bp.bu_bp_history_o, bp.count_o, bp.spec_history_o);
    end
    step();
    checks++;
    if (bp.bu_bp_update_o !== 1'b0 || bp.count_o !== 3'd0) begin
      errors++; $display("FAIL flush_after: got upd=%b count=%0d expected 0 0", bp.bu_bp_update_o, bp.count_o);
    end
  endtask
  task automatic test_empty();
    resolve(64'h500, 1'b1);
    checks++;
    if (bp.bu_bp_update_o !== 1'b0 || bp.error_o !== 1'b1) begin
      errors++; $display("FAIL empty_res: got upd=%b err=%b expected 0 1", bp.bu_bp_update_o, bp.error_o);
    end
    step(); step();
    checks++;
    if (bp.error_o !== 1'b1) begin
      errors++; $display("FAIL empty_sticky: got err=%b expected 1", bp.error_o);
    end
    do_reset();
    checks++;
    if (bp.error_o !== 1'b0) begin
      errors++; $display("FAIL empty_clear: got err=%b expected 0", bp.error_o);
    end
  endtask
  task automatic test_reset_mid();
    push(2'b11);
    rst = 1; bp.ex_resolve_i = 1; bp.ex_pc_i = 64'h600; bp.ex_btaken_i = 1;
    step();
    idle();
    rst = 0;
    checks++;
    if ({bp.bu_bp_update_o, bp.mispredict_o, bp.count_o, bp.spec_history_o, bp.error_o, bp.bu_bp_pc_o} !== 72'd0) begin
      errors++; $display("FAIL rstmid_state: got upd=%b mis=%b count=%0d spec=%b err=%b pc=%h expected all 0", bp.bu_bp_update_o, bp.mispredict_o, bp.count_o, bp.spec_history_o, bp.error_o, bp.bu_bp_pc_o);
    end
    step();
    checks++;
    if (bp.bu_bp_update_o !== 1'b0 || bp.count_o !== 3'd0) begin
      errors++; $display("FAIL rstmid_after: got upd=%b count=%0d expected 0 0", bp.bu_bp_update_o, bp.count_o);
    end
  endtask
  initial begin
    idle();
    test_reset();
    test_back_to_back();
    test_full();
    test_mispredict();
    test_flush();
    test_empty();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pu_riscv_bp_resolve.md
# pu_riscv_bp_resolve

Resolution-side companion to the correlating branch predictor: tracks every predicted branch from decode to execute, maintains the speculative and committed global history, and generates the predictor update stream. It consumes the 2-bit prediction the predictor hands to decode. At execute it compares the prediction with the actual outcome, drives the registered update port back into the predictor, and raises a mispredict pulse for the pipeline.

## Interface
- XLEN, 64, PC width
- BP_GLOBAL_BITS, 2, global history length
- DEPTH, 4, in-flight branch entries (power of two, >= 2)
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, synchronous, active-high
- id_push_i  in  1  branch leaves decode; capture its prediction
- id_predict_i  in  2  predictor counter bits for that branch; bit 1 = predicted taken
- id_stall_o  out  1  in-flight queue full; decode must hold branches
- ex_resolve_i  in  1  oldest in-flight branch resolved in execute
- ex_pc_i  in  XLEN  PC of the resolving branch
- ex_btaken_i  in  1  actual outcome
- ex_flush_i  in  1  pipeline flush (exception/trap); discard all in-flight branches
- spec_history_o  out  BP_GLOBAL_BITS  speculative global history for predictor indexing
- bu_bp_update_o  out  1  predictor update strobe
- bu_bp_pc_o  out  XLEN  update PC
- bu_bp_history_o  out  BP_GLOBAL_BITS  history the branch was predicted with
- bu_bp_predict_o  out  2  prediction bits used
- bu_bp_btaken_o  out  1  actual outcome
- mispredict_o  out  1  one-cycle mispredict pulse
- count_o  out  $clog2(DEPTH)+1  entries in flight
- error_o  out  1  sticky protocol error

## Operation
- Queue: circular FIFO, entry = {predict[1:0], history[BP_GLOBAL_BITS-1:0]}; rd/wr pointers wrap modulo DEPTH.
- Push (accepted): entry stores id_predict_i and current spec history; spec history shifts left, LSB = id_predict_i[1].
- Resolve: pops head. Committed history shifts left, LSB = ex_btaken_i. Next cycle: bu_bp_update_o=1, pc/history/predict from the popped entry and ex_pc_i, btaken = ex_btaken_i.
- Mispredict (ex_btaken_i != head predict[1]): mispredict_o=1 with the update; queue cleared (count 0); spec history := new committed history; any same-cycle push discarded.
- Correct resolve + push same cycle: both take effect, count unchanged, allowed when full; spec history applies push shift only.
- Flush: queue cleared, spec history := committed history (after any same-cycle resolve shift). A same-cycle resolve is processed first and its update still issues. A same-cycle push is discarded.
- Push while full without a same-cycle resolve: dropped, error_o set.
- Resolve while empty: ignored, no update, error_o set.
- id_stall_o = (count == DEPTH), combinational from count.
- error_o clears only on reset.
- Precedence per cycle: reset > resolve > flush > push.

## Timing
- Reset: all outputs 0, both histories 0, pointers 0, count 0, error_o 0.
- Resolve to bu_bp_update_o / mispredict_o: exactly 1 cycle, each high for 1 cycle per resolve.
- spec_history_o and count_o are registered and reflect pushes, restores and flushes the cycle after.
- Back-to-back resolves give back-to-back update strobes with no bubble.
- Reset asserted mid-operation discards all entries and any pending update; no update strobe appears the cycle after reset.

## Test plan
- Reset, then push predict=2'b11, 2'b00, then resolve taken, not-taken (pc 0x100, 0x104) -> two updates with history 2'b00 then 2'b01, predict 11 then 00, no mispredict; spec_history_o 2'b10.
- Push 4 entries (DEPTH=4) -> id_stall_o=1, count 4. A 5th push sets error_o. A push plus resolve in the same cycle while full keeps count 4 and sets no error.
- Push predict=2'b10, 2'b10, 2'b10, then resolve the first not-taken -> mispredict_o=1 the next cycle, count 0, spec_history_o = committed history (2'b00), younger entries give no update.
- Push 3 entries, assert ex_flush_i together with a correct resolve -> one update strobe, count 0, spec_history_o equals committed history.
- Resolve with an empty queue -> no bu_bp_update_o, error_o=1 sticky until rst_i.
- Assert rst_i in the same cycle as a resolve -> no update strobe the next cycle, all outputs 0.
